// File: rtl/fb_line_reader_if.sv
// fb_line_reader_if
//   SDRAM arbiter read port seen by the framebuffer line reader.
//   master modport: the read master (fb_line_reader)
//   slave modport : the arbiter side
//   Signals:
//     sdram_rd      master->slave  read request, held until sdram_ac
//     sdram_addr    master->slave  22-bit word address of current request
//     sdram_wait    slave->master  arbiter busy, no new read may start
//     sdram_ac      slave->master  read accepted this cycle
//     sdram_rdvalid slave->master  sdram_rdata valid (issue order)
//     sdram_rdata   slave->master  128-bit read data
interface fb_line_reader_if;
    logic         sdram_rd;
    logic [21:0]  sdram_addr;
    logic         sdram_wait;
    logic         sdram_ac;
    logic         sdram_rdvalid;
    logic [127:0] sdram_rdata;

    modport master (
        output sdram_rd,
        output sdram_addr,
        input  sdram_wait,
        input  sdram_ac,
        input  sdram_rdvalid,
        input  sdram_rdata
    );

    modport slave (
        input  sdram_rd,
        input  sdram_addr,
        output sdram_wait,
        output sdram_ac,
        output sdram_rdvalid,
        output sdram_rdata
    );
endinterface

// File: rtl/fb_line_reader.sv
// fb_line_reader
//   Scanout-side SDRAM read master. Each accepted line request fetches
//   WORDS_PER_LINE 128-bit words from the display buffer (the one not being
//   drawn) and writes them into one bank of a ping-pong line buffer.
//
//   Optional feature macro: FBR_BLANK_EN
//     defined   : extra input 'blank'; a blank line is filled with zero words
//                 on consecutive cycles without any SDRAM read.
//     undefined : every line is read from SDRAM.
//
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous, active-low reset
//     frame_flip buffer currently drawn (1 = OFFSET1)
//     new_frame  frame-start pulse, latches the display select
//     line_req   line fetch request pulse
//     line_num   line to fetch (sampled with line_req)
//     line_bank  line-buffer bank to fill (sampled with line_req)
//     blank      (FBR_BLANK_EN only) fill the line with zeros
//     sdram      SDRAM arbiter read port (master modport)
//     lb_wr      line-buffer write strobe
//     lb_addr    line-buffer address {bank, word index}
//     lb_data    line-buffer write data
//     busy       fetch in progress
//     done       pulse one cycle after the last line-buffer write
//     overrun    sticky flag: a request was dropped
module fb_line_reader #(
    parameter int unsigned WORDS_PER_LINE  = 40,
    parameter int unsigned LINES           = 480,
    parameter logic [21:0] OFFSET0         = 22'h100000,
    parameter logic [21:0] OFFSET1         = 22'h200000,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_flip,
    input  logic              new_frame,
    input  logic              line_req,
    input  logic [8:0]        line_num,
    input  logic              line_bank,
`ifdef FBR_BLANK_EN
    input  logic              blank,
`endif
    fb_line_reader_if.master  sdram,
    output logic              lb_wr,
    output logic [6:0]        lb_addr,
    output logic [127:0]      lb_data,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAUSE,
        S_ISSUE,
        S_DRAIN,
        S_BLANK
    } state_t;

    localparam logic [5:0] WPL  = 6'(WORDS_PER_LINE);
    localparam logic [3:0] MAXO = 4'(MAX_OUTSTANDING);

    state_t       state;
    state_t       state_nx;
    logic         disp_sel;
    logic         bank_q;
    logic         rd_held;
    logic         rd;
    logic [5:0]   issued;
    logic [5:0]   received;
    logic [3:0]   outstanding;
    logic [21:0]  addr_q;
    logic [21:0]  base;
    logic         blank_sel;
    logic         start;
    logic         start_blank;
    logic         accept;
    logic         rdv_ok;

`ifdef FBR_BLANK_EN
    assign blank_sel = blank;
`else
    assign blank_sel = 1'b0;
`endif

    assign base        = (disp_sel ? OFFSET1 : OFFSET0)
                       + 22'(line_num) * 22'(WORDS_PER_LINE);
    assign start       = line_req && (state == S_IDLE) && (32'(line_num) < LINES);
    assign start_blank = start && blank_sel;
    assign accept      = rd && sdram.sdram_ac;
    // Data with nothing outstanding is stale (e.g. issued before a reset).
    assign rdv_ok      = sdram.sdram_rdvalid && (outstanding != 4'd0);
    assign busy        = (state != S_IDLE);

    assign sdram.sdram_rd   = rd;
    assign sdram.sdram_addr = addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rd       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (blank_sel)
                        state_nx = S_BLANK;
                    else if (sdram.sdram_wait)
                        state_nx = S_PAUSE;
                    else
                        state_nx = S_ISSUE;
                end
            end
            S_PAUSE: begin
                if (!sdram.sdram_wait)
                    state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                // A request already on the bus is held regardless of wait;
                // a fresh one needs wait low and room in the outstanding window.
                rd = rd_held || (!sdram.sdram_wait && (outstanding < MAXO));
                if (rd && sdram.sdram_ac && (issued == WPL - 6'd1))
                    state_nx = S_DRAIN;
                else if (sdram.sdram_wait && !rd)
                    state_nx = S_PAUSE;
            end
            S_DRAIN: begin
                if (received == WPL)
                    state_nx = S_IDLE;
            end
            S_BLANK: begin
                if (received == WPL)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_sel    <= 1'b0;
            bank_q      <= 1'b0;
            rd_held     <= 1'b0;
            issued      <= '0;
            received    <= '0;
            outstanding <= '0;
            addr_q      <= '0;
            lb_wr       <= 1'b0;
            lb_addr     <= '0;
            lb_data     <= '0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (new_frame)
                disp_sel <= ~frame_flip;

            if (line_req && ((state != S_IDLE) || (32'(line_num) >= LINES)))
                overrun <= 1'b1;

            rd_held <= rd && !sdram.sdram_ac;

            if (start) begin
                addr_q   <= base;
                bank_q   <= line_bank;
                issued   <= '0;
                received <= '0;
            end else if (accept) begin
                addr_q <= addr_q + 22'd1;
                issued <= issued + 6'd1;
            end

            case ({accept, rdv_ok})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase

            lb_wr <= 1'b0;
            if (rdv_ok) begin
                lb_wr    <= 1'b1;
                lb_addr  <= {bank_q, received};
                lb_data  <= sdram.sdram_rdata;
                received <= received + 6'd1;
            end

            // Blank lines write word 0 straight from the request cycle so the
            // zero fill runs on consecutive cycles.
            if (start_blank) begin
                lb_wr    <= 1'b1;
                lb_addr  <= {line_bank, 6'd0};
                lb_data  <= '0;
                received <= 6'd1;
            end else if ((state == S_BLANK) && (received != WPL)) begin
                lb_wr    <= 1'b1;
                lb_addr  <= {bank_q, received};
                lb_data  <= '0;
                received <= received + 6'd1;
            end

            done <= ((state == S_DRAIN) || (state == S_BLANK)) && (received == WPL);
        end
    end

endmodule

// File: tb/tb_fb_line_reader.sv
// tb_fb_line_reader
//   Randomized self-checking bench for fb_line_reader. A behavioural arbiter
//   (random wait/accept, fixed per-line latency, in-order return) drives the
//   read port; expected line-buffer writes are computed from the line base
//   address arithmetic and compared in order.
module tb_fb_line_reader;

    localparam int unsigned WPL  = 40;
    localparam int unsigned MAXO = 4;
    localparam logic [21:0] OFF0 = 22'h100000;
    localparam logic [21:0] OFF1 = 22'h200000;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         frame_flip = 1'b0;
    logic         new_frame = 1'b0;
    logic         line_req = 1'b0;
    logic [8:0]   line_num = '0;
    logic         line_bank = 1'b0;
`ifdef FBR_BLANK_EN
    logic         blank = 1'b0;
`endif
    logic         lb_wr;
    logic [6:0]   lb_addr;
    logic [127:0] lb_data;
    logic         busy;
    logic         done;
    logic         overrun;

    fb_line_reader_if sif ();

    always #5 clk = ~clk;

    fb_line_reader #(
        .WORDS_PER_LINE  (40),
        .LINES           (480),
        .OFFSET0         (22'h100000),
        .OFFSET1         (22'h200000),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_flip (frame_flip),
        .new_frame  (new_frame),
        .line_req   (line_req),
        .line_num   (line_num),
        .line_bank  (line_bank),
`ifdef FBR_BLANK_EN
        .blank      (blank),
`endif
        .sdram      (sif.master),
        .lb_wr      (lb_wr),
        .lb_addr    (lb_addr),
        .lb_data    (lb_data),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    typedef struct {
        int unsigned due;
        logic [21:0] addr;
        bit          stale;
    } pend_t;

    typedef struct {
        logic [6:0]   a;
        logic [127:0] d;
    } word_t;

    pend_t       pend_q[$];
    word_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned tb_out = 0;
    bit          live_ret = 0;
    logic [21:0] exp_addr = '0;
    bit          prev_held = 0;
    logic [21:0] prev_addr = '0;
    int unsigned wait_pct = 0;
    int unsigned ac_pct = 100;
    int unsigned lat = 3;
    int unsigned ac_hold = 0;
    bit          disp_model = 0;
    bit          blank_mode = 0;
    bit          line_active = 0;
    int unsigned done_cnt = 0;
    int unsigned done_cyc = 0;
    int unsigned last_wr_cyc = 0;
    int unsigned accepts = 0;
    int unsigned req_cyc = 0;
    bit          chk_start = 0;
    bit          start_rd_exp = 0;
    logic [21:0] start_base = '0;

    function automatic logic [127:0] word_of(input logic [21:0] a);
        logic [31:0] x;
        x = 32'(a);
        return {x ^ 32'hC0DE0000, x * 32'd2654435761, ~x, x + 32'h13579BDF};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        logic ac;
        ac = 1'b0;
        @(negedge clk);
        if (reset) begin
            if (lb_wr) begin
                if (exp_q.size() == 0) begin
                    check("lb_wr_unexpected", lb_wr, 1'b0);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    check("lb_addr", lb_addr, w.a);
                    check("lb_data", lb_data, w.d);
                end
                last_wr_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_after_last_wr", cyc - last_wr_cyc, 1);
            end
            if (chk_start) begin
                chk_start = 0;
                check("busy_start", busy, 1'b1);
                if (!blank_mode)
                    check("addr_start", sif.sdram_addr, start_base);
                if (start_rd_exp)
                    check("rd_start", sif.sdram_rd, 1'b1);
            end
            if (prev_held) begin
                check("rd_held", sif.sdram_rd, 1'b1);
                check("addr_held", sif.sdram_addr, prev_addr);
            end else if (sif.sdram_rd) begin
                check("rd_start_wait_low", sif.sdram_wait, 1'b0);
            end
            if (sif.sdram_rd)
                check("outstanding_cap", tb_out < MAXO, 1'b1);
            if (blank_mode && sif.sdram_rd)
                check("blank_no_rd", sif.sdram_rd, 1'b0);
            ac = sif.sdram_rd && (ac_hold == 0) && ($urandom_range(99) < ac_pct);
            if (ac) begin
                check("rd_addr", sif.sdram_addr, exp_addr);
                exp_addr = exp_addr + 22'd1;
                tb_out++;
                accepts++;
                pend_q.push_back('{due: cyc + lat, addr: sif.sdram_addr, stale: 1'b0});
            end
            prev_held = sif.sdram_rd && !ac;
            prev_addr = sif.sdram_addr;
        end
        sif.sdram_ac = ac;
        if (ac_hold > 0)
            ac_hold--;
        @(posedge clk);
        #1;
        cyc++;
        if (live_ret) begin
            tb_out--;
            live_ret = 0;
        end
        sif.sdram_ac      = 1'b0;
        sif.sdram_wait    = ($urandom_range(99) < wait_pct);
        sif.sdram_rdvalid = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            pend_t p;
            p = pend_q.pop_front();
            sif.sdram_rdvalid = 1'b1;
            sif.sdram_rdata   = word_of(p.addr);
            if (!p.stale)
                live_ret = 1;
        end
    endtask

    task automatic set_arb(input int unsigned wp, input int unsigned ap, input int unsigned l);
        wait_pct = wp;
        ac_pct   = ap;
        lat      = l;
    endtask

    task automatic frame(input bit flip);
        frame_flip = flip;
        new_frame  = 1'b1;
        tick();
        new_frame  = 1'b0;
        disp_model = ~flip;
    endtask

    task automatic request(input int unsigned num, input bit bank, input bit blk);
        bit          ok;
        logic [21:0] b;
        ok = !line_active && (num < 480);
        line_num  = 9'(num);
        line_bank = bank;
`ifdef FBR_BLANK_EN
        blank = blk;
`endif
        line_req = 1'b1;
        if (ok) begin
            b = (disp_model ? OFF1 : OFF0) + 22'(num * WPL);
            for (int unsigned i = 0; i < WPL; i++)
                exp_q.push_back('{a: {bank, 6'(i)}, d: (blk ? 128'd0 : word_of(b + 22'(i)))});
            exp_addr     = b;
            start_base   = b;
            start_rd_exp = (wait_pct == 0) && !blk;
            blank_mode   = blk;
            line_active  = 1;
            accepts      = 0;
            req_cyc      = cyc;
        end
        tick();
        line_req = 1'b0;
`ifdef FBR_BLANK_EN
        blank = 1'b0;
`endif
        if (ok)
            chk_start = 1;
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned d0;
        int unsigned n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check("done_seen", done_cnt != d0, 1'b1);
        repeat (3) tick();
        check("done_single", done_cnt - d0, 1);
        check("words_all_written", exp_q.size(), 0);
        check("busy_after_done", busy, 1'b0);
        line_active = 0;
        blank_mode  = 0;
    endtask

    task automatic check_reset_vals();
        check("rst_sdram_rd", sif.sdram_rd, 1'b0);
        check("rst_sdram_addr", sif.sdram_addr, 22'd0);
        check("rst_lb_wr", lb_wr, 1'b0);
        check("rst_lb_addr", lb_addr, 7'd0);
        check("rst_lb_data", lb_data, 128'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_overrun", overrun, 1'b0);
    endtask

    initial begin
        int unsigned n;
        sif.sdram_wait    = 1'b0;
        sif.sdram_ac      = 1'b0;
        sif.sdram_rdvalid = 1'b0;
        sif.sdram_rdata   = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_reset_vals();

        // Buffer 1 displayed, line 0, bank 0, quick arbiter.
        set_arb(0, 100, 3);
        frame(1'b0);
        request(0, 1'b0, 1'b0);
        wait_done(400);

        // Buffer 0 displayed, last line into bank 1, random arbiter.
        set_arb(20, 70, 3);
        frame(1'b1);
        request(479, 1'b1, 1'b0);
        wait_done(2000);

        // Long accept stall then long latency: window must cap at 4.
        set_arb(0, 100, 10);
        ac_hold = 22;
        request(100, 1'b0, 1'b0);
        wait_done(2000);
        check("overrun_clean", overrun, 1'b0);

        // Dropped requests: one while busy, one out of range; new_frame mid-line.
        set_arb(10, 80, 4);
        request(5, 1'b0, 1'b0);
        repeat (12) tick();
        request(7, 1'b1, 1'b0);
        check("overrun_busy_req", overrun, 1'b1);
        frame(1'b0);
        wait_done(2000);
        request(480, 1'b0, 1'b0);
        tick();
        check("busy_bad_line", busy, 1'b0);
        check("overrun_sticky", overrun, 1'b1);
        request(10, 1'b1, 1'b0);
        wait_done(2000);
        check("overrun_still_set", overrun, 1'b1);

        // Reset in the middle of a line, stale returns afterwards.
        set_arb(0, 100, 3);
        request(20, 1'b0, 1'b0);
        n = 0;
        while (accepts < 10 && n < 300) begin
            tick();
            n++;
        end
        check("ten_accepts", accepts >= 10, 1'b1);
        reset = 1'b0;
        exp_q.delete();
        pend_q.delete();
        tb_out      = 0;
        live_ret    = 0;
        prev_held   = 0;
        chk_start   = 0;
        line_active = 0;
        disp_model  = 0;
        repeat (2) tick();
        reset = 1'b1;
        for (int unsigned i = 1; i <= 3; i++)
            pend_q.push_back('{due: cyc + i, addr: 22'(i), stale: 1'b1});
        repeat (6) tick();
        check_reset_vals();
        request(33, 1'b1, 1'b0);
        wait_done(400);

        // Random lines.
        for (int k = 0; k < 5; k++) begin
            set_arb($urandom_range(40), 30 + $urandom_range(70), 1 + $urandom_range(7));
            if ($urandom_range(1) == 1)
                frame(1'($urandom_range(1)));
            request($urandom_range(479), 1'($urandom_range(1)), 1'b0);
            wait_done(3000);
        end

`ifdef FBR_BLANK_EN
        set_arb(0, 100, 3);
        request(200, 1'b1, 1'b1);
        wait_done(200);
        check("blank_done_cycle", done_cyc - req_cyc, 41);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
